// File: rtl/bin2seg_defs.sv
// Shared segment patterns (active-low, bit0=a .. bit6=g), FSM encoding and
// a constant-power helper for the bin2seg_scan display driver.
package bin2seg_defs;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; 10..15 blank.
module seg7_decode
   import bin2seg_defs::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: the default arm gives seg a value on every path, so no latch is inferred.
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bin2seg_scan.sv
// Sequential double-dabble binary-to-BCD converter driving a multiplexed
// common-anode display. Define BIN2SEG_LZB_EN for leading-zero blanking.
module bin2seg_scan
   import bin2seg_defs::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 1000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   // ceil(WIDTH/3) digits always hold 2^WIDTH-1, since 8^k < 10^k
   localparam int ACC_DIGITS = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
   localparam int ACC_W      = 4 * ACC_DIGITS;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam int PRE_W      = $clog2(REFRESH_DIV);
   localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CMP_W      = (WIDTH > 32) ? WIDTH : 32;
   localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(pow10(DIGITS) - 1);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      sr_q, sr_d, sr_shift;
   logic [ACC_W-1:0]      acc_q, acc_d, acc_adj, acc_shift;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_pend_q, ovf_pend_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  ovf_q, ovf_d;
   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [6:0]            seg_q, seg_d, dec_seg;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [3:0]            nib_sel;
   logic                  wrap, lead_zero;

   // One double-dabble step: correct nibbles >= 5, then shift left through both registers
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < ACC_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      acc_shift = {acc_adj[ACC_W-2:0], sr_q[WIDTH-1]};
      sr_shift  = {sr_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sr_d       = bin;
               acc_d      = '0;
               cnt_d      = CNT_W'(WIDTH);
               ovf_pend_d = CMP_W'(bin) > MAX_VAL;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = sr_shift;
            acc_d = acc_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
               ovf_d   = ovf_pend_q;
               bcd_d   = ovf_pend_q ? '0 : acc_shift[4*DIGITS-1:0];
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Refresh scan: an and seg are both captured on the prescaler wrap edge
   always_comb begin
      wrap    = (presc_q == PRE_W'(REFRESH_DIV - 1));
      presc_d = wrap ? '0 : presc_q + PRE_W'(1);
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      nib_sel = bcd_q[4*int'(idx_q) +: 4];
`ifdef BIN2SEG_LZB_EN
      lead_zero = (idx_q != '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx_q) && bcd_q[4*i +: 4] != 4'd0) lead_zero = 1'b0;
      end
`else
      lead_zero = 1'b0;
`endif
      seg_d = seg_q;
      an_d  = an_q;
      if (wrap) begin
         an_d = ~(DIGITS'(1) << idx_q);
         if (ovf_q)          seg_d = SEG_DASH;
         else if (lead_zero) seg_d = SEG_BLANK;
         else                seg_d = dec_seg;
      end
   end

   seg7_decode u_seg7_decode (
      .nibble (nib_sel),
      .seg    (dec_seg)
   );

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= SEG_BLANK;
         an_q       <= '1;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule
